// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake,
// a two-entry skid buffer and a synchronous flush that inserts a bubble.
//
// Parameters:
//   CTRL_W  width of the control bundle; all-zero encodes a NOP
//   DATA_W  width of the data bundle
// Ports:
//   Clk        clock, rising edge
//   Rst_n      asynchronous active-low reset
//   In_valid   upstream presents an instruction
//   In_ready   stage can accept (registered, no path from Out_ready)
//   In_ctrl    control bundle in
//   In_data    data bundle in
//   Flush      squash all held entries and the current input
//   Out_valid  Out_ctrl/Out_data hold a live instruction
//   Out_ready  downstream accepts
//   Out_ctrl   control bundle out, forced to 0 while Out_valid=0
//   Out_data   data bundle out, don't-care while Out_valid=0
//   Occupancy  number of held entries (0, 1 or 2)
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 20,
  parameter int unsigned DATA_W = 192
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [CTRL_W-1:0] In_ctrl,
  input  logic [DATA_W-1:0] In_data,
  input  logic              Flush,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [CTRL_W-1:0] Out_ctrl,
  output logic [DATA_W-1:0] Out_data,
  output logic [1:0]        Occupancy
);

  // State encoding equals the occupancy count. Main is valid in StOne and
  // StTwo; the skid entry is valid only in StTwo.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  logic accept;
  logic issue;

  assign accept = In_valid & in_ready_q;
  assign issue  = (state_q != StEmpty) & Out_ready;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !issue) begin
            state_d = StTwo;
          end else if (!accept && issue) begin
            state_d = StEmpty;
          end
        end
        StTwo:   if (issue) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Entry datapath. Flush clears ctrl so a squashed slot reads as a NOP, but
  // leaves data untouched since it is don't-care once invalid.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (Flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_ctrl_d = In_ctrl;
            main_data_d = In_data;
          end
        end
        StOne: begin
          if (accept && issue) begin
            main_ctrl_d = In_ctrl;
            main_data_d = In_data;
          end else if (accept) begin
            skid_ctrl_d = In_ctrl;
            skid_data_d = In_data;
          end else if (issue) begin
            main_ctrl_d = '0;
          end
        end
        StTwo: begin
          // Skid is older than anything new, so it always refills main first.
          if (issue) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Ready is precomputed from the next state so it never depends
  // combinationally on Out_ready.
  assign in_ready_d = (state_d != StTwo);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Outputs
  always_comb begin
    Out_valid = (state_q != StEmpty);
    Out_ctrl  = Out_valid ? main_ctrl_q : '0;
    Out_data  = main_data_q;
    In_ready  = in_ready_q;
    Occupancy = state_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a driver pushes the expected item
// whenever it sees an accept, and a monitor pops and compares on every issue.
module tb_pipe_stage_reg;

  localparam int unsigned CtrlW = 20;
  localparam int unsigned DataW = 192;

  typedef struct packed {
    logic [CtrlW-1:0] c;
    logic [DataW-1:0] d;
  } item_t;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             In_valid;
  logic             In_ready;
  logic [CtrlW-1:0] In_ctrl;
  logic [DataW-1:0] In_data;
  logic             Flush;
  logic             Out_valid;
  logic             Out_ready;
  logic [CtrlW-1:0] Out_ctrl;
  logic [DataW-1:0] Out_data;
  logic [1:0]       Occupancy;

  item_t exp_q[$];
  int    n_total   = 0;
  int    n_pass    = 0;
  int    issue_cnt = 0;

  pipe_stage_reg #(
    .CTRL_W(CtrlW),
    .DATA_W(DataW)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .In_ctrl  (In_ctrl),
    .In_data  (In_data),
    .Flush    (Flush),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Out_ctrl (Out_ctrl),
    .Out_data (Out_data),
    .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DataW-1:0] mk_data(input logic [CtrlW-1:0] c);
    logic [23:0] w;
    w = {4'h0, c} ^ 24'h5A5A5A;
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic chk_wide(input string name, input logic [DataW-1:0] act,
                          input logic [DataW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // One cycle of stimulus: inputs change just after a rising edge, the accept
  // decision is taken at the falling edge, and a flush empties the scoreboard
  // once the monitor has had the chance to see the flush-cycle issue.
  task automatic drive(input logic v, input logic [CtrlW-1:0] c, input logic fl,
                       input logic ordy);
    item_t it;
    In_valid  = v;
    In_ctrl   = c;
    In_data   = mk_data(c);
    Flush     = fl;
    Out_ready = ordy;
    @(negedge Clk);
    if (!fl && v && In_ready) begin
      it.c = c;
      it.d = mk_data(c);
      exp_q.push_back(it);
    end
    @(posedge Clk);
    #1;
    if (fl) exp_q.delete();
    In_valid = 1'b0;
    Flush    = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge Clk) begin
    item_t it;
    if (Rst_n === 1'b1) begin
      if (Out_valid !== 1'b1) begin
        chk("ctrl_zero_idle", 32'(Out_ctrl), 32'd0);
      end else if (Out_ready === 1'b1) begin
        issue_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_issue: got ctrl %0h, required no output", Out_ctrl);
        end else begin
          it = exp_q.pop_front();
          chk("sb_ctrl", 32'(Out_ctrl), 32'(it.c));
          chk_wide("sb_data", Out_data, it.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issued_before;
    Rst_n     = 1'b1;
    In_valid  = 1'b0;
    In_ctrl   = '0;
    In_data   = '0;
    Flush     = 1'b0;
    Out_ready = 1'b0;

    // Asynchronous reset with no clock edge
    #1 Rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_out_ctrl", 32'(Out_ctrl), 32'd0);
    chk("rst_in_ready", 32'(In_ready), 32'd1);
    chk("rst_occupancy", 32'(Occupancy), 32'd0);
    chk_wide("rst_out_data", Out_data, '0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, CtrlW'(i), 1'b0, 1'b1);
      chk("stream_occ", 32'(Occupancy), 32'd1);
      chk("stream_out", 32'(Out_ctrl), 32'(i));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("stream_drain", 32'(Occupancy), 32'd0);

    // Back-pressure: A then B fill both entries
    drive(1'b1, 20'h0000A, 1'b0, 1'b0);
    drive(1'b1, 20'h0000B, 1'b0, 1'b0);
    chk("bp_occ2", 32'(Occupancy), 32'd2);
    chk("bp_in_ready", 32'(In_ready), 32'd0);
    chk("bp_head", 32'(Out_ctrl), 32'h0000A);
    drive(1'b1, 20'h000EE, 1'b0, 1'b0);  // refused while full
    chk("bp_refuse_occ", 32'(Occupancy), 32'd2);
    drive(1'b0, '0, 1'b0, 1'b1);          // A issues
    chk("bp_after_a_occ", 32'(Occupancy), 32'd1);
    chk("bp_after_a_ready", 32'(In_ready), 32'd1);
    chk("bp_after_a_head", 32'(Out_ctrl), 32'h0000B);
    drive(1'b0, '0, 1'b0, 1'b1);          // B issues
    chk("bp_empty", 32'(Occupancy), 32'd0);

    // Flush while full, with C presented in the flush cycle
    drive(1'b1, 20'h000A2, 1'b0, 1'b0);
    drive(1'b1, 20'h000B2, 1'b0, 1'b0);
    drive(1'b1, 20'h0000C, 1'b1, 1'b0);
    chk("flush2_valid", 32'(Out_valid), 32'd0);
    chk("flush2_ctrl", 32'(Out_ctrl), 32'd0);
    chk("flush2_occ", 32'(Occupancy), 32'd0);
    chk("flush2_ready", 32'(In_ready), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("flush2_still_empty", 32'(Occupancy), 32'd0);

    // Flush with a simultaneous issue at occupancy 1
    drive(1'b1, 20'h000E1, 1'b0, 1'b0);
    issued_before = issue_cnt;
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("flush1_issue_once", 32'(issue_cnt - issued_before), 32'd1);
    chk("flush1_occ", 32'(Occupancy), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("flush1_no_repeat", 32'(issue_cnt - issued_before), 32'd1);

    // Reset while full, then D after release
    drive(1'b1, 20'h000A3, 1'b0, 1'b0);
    drive(1'b1, 20'h000B3, 1'b0, 1'b0);
    chk("rst2_pre_occ", 32'(Occupancy), 32'd2);
    #1 Rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst2_valid", 32'(Out_valid), 32'd0);
    chk("rst2_ctrl", 32'(Out_ctrl), 32'd0);
    chk("rst2_occ", 32'(Occupancy), 32'd0);
    chk("rst2_ready", 32'(In_ready), 32'd1);
    chk_wide("rst2_data", Out_data, '0);
    #1 Rst_n = 1'b1;
    drive(1'b1, 20'h0000D, 1'b0, 1'b1);
    chk("rst2_d_out", 32'(Out_ctrl), 32'h0000D);
    chk("rst2_d_valid", 32'(Out_valid), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("final_empty", 32'(Occupancy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
